// File: rtl/jtkunio_sndlatch.sv
// Sound latch between the main CPU and the sound CPU.
// The main CPU pushes bytes on the rising edge of snd_wr. The sound CPU pops them
// on the falling edge of latch_rd. irq_n stays low while any byte is pending.
// Build option: define JTKUNIO_SNDFIFO_EN for a 2^FIFO_AW-deep FIFO.
// Without it the store is a single overwrite-on-push register and FIFO_AW is ignored.
module jtkunio_sndlatch #(
    parameter int FIFO_AW = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       snd_wr,
    input  logic [7:0] snd_din,
    input  logic       latch_rd,
    input  logic       ovr_clr,
    output logic [7:0] latch_dout,
    output logic       irq_n,
    output logic [2:0] level,
    output logic       overrun
);

`ifdef JTKUNIO_SNDFIFO_EN
    localparam int DEPTH = 1 << FIFO_AW;
    localparam int LW    = FIFO_AW + 1;
`else
    // FIFO_AW is accepted for interface compatibility but has no effect here
    localparam int DEPTH = 1;
    localparam int LW    = 1 + 0 * FIFO_AW;
`endif
    localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);
    localparam logic [LW-1:0] LVL_ONE  = LW'(1);

    // Edge-detect samples and write arming
    logic          wr_q, rd_q;
    logic          arm_q, arm_d;

    // Occupancy and registered outputs
    logic [LW-1:0] level_q, level_d;
    logic [7:0]    dout_q, dout_d;
    logic          irq_n_q, irq_n_d;
    logic          ovr_q, ovr_d;

    // Per-cycle events
    logic          push_det, pop_det;
    logic          empty, full;
    logic          push_ok, pop_ok;
    logic          ovr_evt;
    logic [7:0]    head;

    // Decode bus edges into push/pop events and decide which take effect.
    // arm_q blocks a push until snd_wr has been seen low after reset.
    always_comb begin
        push_det = snd_wr & ~wr_q & arm_q;
        pop_det  = rd_q & ~latch_rd;
        empty    = (level_q == '0);
        full     = (level_q == LVL_FULL);
        pop_ok   = pop_det & ~empty;
`ifdef JTKUNIO_SNDFIFO_EN
        // A full FIFO still accepts a push if a slot frees on the same edge
        push_ok  = push_det & (~full | pop_ok);
`else
        // The single register is always overwritten
        push_ok  = push_det;
`endif
        ovr_evt  = push_det & full & ~pop_ok;
        arm_d    = arm_q | ~snd_wr;
    end

`ifdef JTKUNIO_SNDFIFO_EN
    logic [7:0]         mem_q [DEPTH];
    logic [FIFO_AW-1:0] wptr_q, wptr_d;
    logic [FIFO_AW-1:0] rptr_q, rptr_d;

    // Pointer and level next-state; pointers wrap naturally at 2^FIFO_AW
    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        level_d = level_q;
        if (push_ok) wptr_d = wptr_q + FIFO_AW'(1);
        if (pop_ok)  rptr_d = rptr_q + FIFO_AW'(1);
        if (push_ok && !pop_ok)
            level_d = level_q + LVL_ONE;
        else if (!push_ok && pop_ok)
            level_d = level_q - LVL_ONE;
        head = mem_q[rptr_q];
    end

    // FIFO pointers, cleared by reset so pending bytes are discarded
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    // FIFO storage; contents are meaningless until written so no reset
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wptr_q] <= snd_din;
    end
`else
    logic [7:0] reg_q;

    // Single-entry occupancy: any push fills it, a pop alone empties it
    always_comb begin
        level_d = level_q;
        if (push_ok)
            level_d = LVL_ONE;
        else if (pop_ok)
            level_d = '0;
        head = reg_q;
    end

    // Single data register; overwritten on every accepted push
    always_ff @(posedge clk) begin
        if (push_ok) reg_q <= snd_din;
    end
`endif

    // Output next-state: dout tracks the head while non-empty and holds otherwise.
    // A new overrun event outranks a clear in the same cycle.
    always_comb begin
        dout_d  = empty ? dout_q : head;
        irq_n_d = empty;
        ovr_d   = ovr_q;
        if (ovr_evt)
            ovr_d = 1'b1;
        else if (ovr_clr)
            ovr_d = 1'b0;
    end

    // Control and output registers with asynchronous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q    <= 1'b0;
            rd_q    <= 1'b0;
            arm_q   <= 1'b0;
            level_q <= '0;
            dout_q  <= 8'h00;
            irq_n_q <= 1'b1;
            ovr_q   <= 1'b0;
        end else begin
            wr_q    <= snd_wr;
            rd_q    <= latch_rd;
            arm_q   <= arm_d;
            level_q <= level_d;
            dout_q  <= dout_d;
            irq_n_q <= irq_n_d;
            ovr_q   <= ovr_d;
        end
    end

    assign latch_dout = dout_q;
    assign irq_n      = irq_n_q;
    assign level      = 3'(level_q);
    assign overrun    = ovr_q;

endmodule

// File: tb/tb_jtkunio_sndlatch.sv
// Self-checking bench for jtkunio_sndlatch.
// The build mode follows JTKUNIO_SNDFIFO_EN, just as the design does.
module tb_jtkunio_sndlatch;

`ifdef JTKUNIO_SNDFIFO_EN
    localparam int DEPTH  = 4;
    localparam bit SINGLE = 1'b0;
`else
    localparam int DEPTH  = 1;
    localparam bit SINGLE = 1'b1;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       snd_wr;
    logic [7:0] snd_din;
    logic       latch_rd;
    logic       ovr_clr;
    logic [7:0] latch_dout;
    logic       irq_n;
    logic [2:0] level;
    logic       overrun;

    jtkunio_sndlatch #(.FIFO_AW(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .snd_wr    (snd_wr),
        .snd_din   (snd_din),
        .latch_rd  (latch_rd),
        .ovr_clr   (ovr_clr),
        .latch_dout(latch_dout),
        .irq_n     (irq_n),
        .level     (level),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    // Reference model state: pending bytes as a queue plus the visible outputs
    logic [7:0] mq[$];
    logic [7:0] m_dout;
    logic       m_irq, m_ovr;
    logic       m_prev_wr, m_prev_rd, m_armed;

    // Scoreboard of expected {dout, irq_n, level, overrun}, one entry per cycle
    logic [12:0] exp_q[$];
    bit          started = 1'b0;
    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc = 0;

    function automatic logic [12:0] model_out();
        return {m_dout, m_irq, 3'(mq.size()), m_ovr};
    endfunction

    task automatic model_reset();
        mq.delete();
        m_dout    = 8'h00;
        m_irq     = 1'b1;
        m_ovr     = 1'b0;
        m_prev_wr = 1'b0;
        m_prev_rd = 1'b0;
        m_armed   = 1'b0;
    endtask

    // Apply the latch rules for one clock edge with the current inputs
    task automatic model_edge();
        bit push, pop, full;
        int sz;
        sz   = mq.size();
        push = snd_wr && !m_prev_wr && m_armed;
        pop  = m_prev_rd && !latch_rd && (sz > 0);
        full = (sz == DEPTH);
        m_dout = (sz > 0) ? mq[0] : m_dout;
        m_irq  = (sz == 0);
        if (pop) void'(mq.pop_front());
        if (push) begin
            if (SINGLE) begin
                mq.delete();
                mq.push_back(snd_din);
            end else if (!full || pop) begin
                mq.push_back(snd_din);
            end
        end
        if (push && full && !pop)
            m_ovr = 1'b1;
        else if (ovr_clr)
            m_ovr = 1'b0;
        m_armed   = m_armed | !snd_wr;
        m_prev_wr = snd_wr;
        m_prev_rd = latch_rd;
        exp_q.push_back(model_out());
    endtask

    task automatic step(input logic wr, input logic [7:0] din, input logic rd, input logic clr);
        snd_wr   = wr;
        snd_din  = din;
        latch_rd = rd;
        ovr_clr  = clr;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic push_byte(input logic [7:0] d);
        step(1'b1, d, 1'b0, 1'b0);
        step(1'b0, d, 1'b0, 1'b0);
    endtask

    task automatic pop_byte();
        step(1'b0, 8'h00, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    // Short reset pulse between clock edges, keeping the inputs as they are
    task automatic reset_pulse();
        @(negedge clk);
        #1 rst_n = 1'b0;
        #2 rst_n = 1'b1;
        model_reset();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    // Monitor: every falling edge after start consumes one expected entry
    initial begin
        logic [12:0] e, act;
        forever begin
            @(negedge clk);
            cyc++;
            if (started) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL scoreboard_empty at cycle %0d: no expected entry for dout=%h irq_n=%b level=%0d ovr=%b",
                             cyc, latch_dout, irq_n, level, overrun);
                end else begin
                    e   = exp_q.pop_front();
                    act = {latch_dout, irq_n, level, overrun};
                    if (act !== e) begin
                        n_bad++;
                        $display("FAIL outputs at cycle %0d: got dout=%h irq_n=%b level=%0d ovr=%b, expected dout=%h irq_n=%b level=%0d ovr=%b",
                                 cyc, act[12:5], act[4], act[3:1], act[0], e[12:5], e[4], e[3:1], e[0]);
                    end
                end
            end
        end
    end

    initial begin
        rst_n    = 1'b0;
        snd_wr   = 1'b0;
        snd_din  = 8'h00;
        latch_rd = 1'b0;
        ovr_clr  = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        exp_q.push_back(model_out());
        started = 1'b1;
        @(negedge clk);
        #1 rst_n = 1'b1;

        // Long write select: exactly one push of 8'h5A
        step(1'b0, 8'h00, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        repeat (10) step(1'b1, 8'h5A, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        pop_byte();
        step(1'b0, 8'h00, 1'b0, 1'b0);

        if (!SINGLE) begin
            // Fill past capacity, then drain one more than stored
            for (int i = 1; i <= 5; i++) push_byte(8'(i));
            step(1'b0, 8'h00, 1'b0, 1'b0);
            for (int i = 0; i < 5; i++) pop_byte();
            step(1'b0, 8'h00, 1'b0, 1'b1);
            // Full store with push and pop completing on the same edge
            for (int i = 0; i < 4; i++) push_byte(8'h10 + 8'(i));
            step(1'b0, 8'h00, 1'b1, 1'b0);
            step(1'b1, 8'hAA, 1'b0, 1'b0);
            step(1'b0, 8'h00, 1'b0, 1'b0);
            for (int i = 0; i < 5; i++) pop_byte();
        end else begin
            // Overwrite, clear the flag, then read back
            push_byte(8'h11);
            push_byte(8'h22);
            step(1'b0, 8'h00, 1'b0, 1'b0);
            step(1'b0, 8'h00, 1'b0, 1'b1);
            step(1'b0, 8'h00, 1'b0, 1'b0);
            pop_byte();
            step(1'b0, 8'h00, 1'b0, 1'b0);
        end

        // Overrun set and clear on the same edge: set wins
        for (int i = 0; i < DEPTH; i++) push_byte(8'hC0 + 8'(i));
        step(1'b1, 8'hEE, 1'b0, 1'b1);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        for (int i = 0; i < DEPTH; i++) pop_byte();

        // Reset mid-operation with snd_wr held high across release
        push_byte(8'h31);
        push_byte(8'h32);
        step(1'b1, 8'h33, 1'b0, 1'b0);
        step(1'b1, 8'h33, 1'b0, 1'b0);
        reset_pulse();
        repeat (3) step(1'b1, 8'h44, 1'b0, 1'b0);
        step(1'b0, 8'h44, 1'b0, 1'b0);
        step(1'b1, 8'h99, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0);

        // Random traffic, with one reset in the middle
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) reset_pulse();
            step(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 15) == 0));
        end
        step(1'b0, 8'h00, 1'b0, 1'b0);

        @(negedge clk);
        #1;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
